spi_master: RTL and testbench

//   Memory-mapped SPI master (mode 0, MSB first, 8-bit frames). It is a bus peripheral beside uart/i2c.
//   - Write strobe: address-decode enable ANDed with CPU write_enable.
//   - Read data: combinational, selected by addr[3:0] and muxed back to the CPU by the data-source mux.
//   - Drives external SCLK/MOSI/CS_N and samples MISO.

---
 rtl/spi_master.sv | 113 +++++++++++
 tb/tb_spi_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Memory-mapped SPI master: mode 0, MSB first, 8-bit frames, software-driven chip select.
// The SCLK half-period is (DIV+1) clk_sys cycles, with DIV captured when a transfer starts.
module spi_master #(
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [3:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t     state, state_nxt;
  logic [7:0] div, div_l, hc, tx_sh, rx_sh, rx;
  logic [2:0] bitcnt;
  logic       cs, done, overrun, busy;
  logic       wr_data, wr_status, wr_ctrl;
  logic       start, phase_end, low_end, high_end, finish;
  logic       unused;

  assign unused    = ^{data_in[31:9], addr[1:0]};
  assign wr_data   = write_enable && (addr[3:2] == 2'd0);
  assign wr_status = write_enable && (addr[3:2] == 2'd1);
  assign wr_ctrl   = write_enable && (addr[3:2] == 2'd2);
  assign busy      = (state != IDLE);
  assign spi_cs_n  = ~cs;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    phase_end = (hc == div_l);
    low_end   = (state == LOW) && phase_end;
    high_end  = (state == HIGH) && phase_end;
    finish    = high_end && (bitcnt == 3'd7);
    case (state)
      IDLE: if (wr_data) begin
        start     = 1'b1;
        state_nxt = LOW;
      end
      LOW:  if (phase_end) state_nxt = HIGH;
      HIGH: if (phase_end) state_nxt = (bitcnt == 3'd7) ? IDLE : LOW;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bus-visible state and pins; reset aborts any transfer in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      cs       <= 1'b0;
      div      <= DIV_RESET;
      rx       <= 8'h00;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_ctrl) {cs, div} <= data_in[8:0];
      // A completing transfer beats a software clear in the same cycle.
      if (finish)                        done <= 1'b1;
      else if (start)                    done <= 1'b0;
      else if (wr_status && data_in[1])  done <= 1'b0;
      if (wr_data && busy)               overrun <= 1'b1;
      else if (wr_status && data_in[2])  overrun <= 1'b0;
      if (start) spi_mosi <= data_in[7];
      if (low_end) spi_sclk <= 1'b1;
      if (high_end) begin
        spi_sclk <= 1'b0;
        if (bitcnt != 3'd7) spi_mosi <= tx_sh[6];
      end
      if (finish) rx <= rx_sh;
    end
  end

  // Shift and timing registers are always loaded at start, so they carry no reset.
  always_ff @(posedge clk_sys) begin
    if (start) begin
      tx_sh  <= data_in[7:0];
      div_l  <= div;
      bitcnt <= 3'd0;
      hc     <= 8'd0;
    end else if (busy) begin
      hc <= phase_end ? 8'd0 : hc + 8'd1;
      if (low_end) rx_sh <= {rx_sh[6:0], spi_miso};
      if (high_end && (bitcnt != 3'd7)) begin
        tx_sh  <= {tx_sh[6:0], 1'b0};
        bitcnt <= bitcnt + 3'd1;
      end
    end
  end

  always_comb begin
    data_out = 32'h0;
    case (addr[3:2])
      2'd0: data_out[7:0] = rx;
      2'd1: data_out[2:0] = {overrun, done, busy};
      2'd2: data_out[8:0] = {cs, div};
      default: data_out = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: directed bus transactions; a pin monitor checks each SPI frame
// against a queue of expected frames while the stimulus checks register reads.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_enable = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        spi_sclk, spi_mosi, spi_miso, spi_cs_n;
  logic        loop = 1'b1;
  logic        miso_fix = 1'b0;

  typedef struct {
    logic [7:0] mosi;
    int         half;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  assign spi_miso = loop ? spi_mosi : miso_fix;

  spi_master #(.DIV_RESET(8'd3)) dut (
    .clk_sys(clk), .reset(reset), .write_enable(write_enable), .addr(addr),
    .data_in(data_in), .data_out(data_out), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    write_enable = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    write_enable = 1'b0; data_in = 32'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    addr = a; #1;
    d = data_out;
  endtask

  // Counts clock edges until STATUS.busy drops; called just after the DATA write edge.
  task automatic wait_idle(output int n);
    logic [31:0] st;
    n = 0;
    bus_read(4'h4, st);
    while (st[0] && n < 5000) begin
      @(posedge clk); #1;
      n++;
      bus_read(4'h4, st);
    end
    if (n >= 5000) begin
      n_cmp++; n_fail++;
      $display("FAIL busy_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  // Pin monitor: assembles MOSI at each SCLK rise, measures phase widths, checks at last fall.
  initial begin
    logic prev;
    logic [7:0] sh;
    int run, cnt, hmin, hmax, lmin, lmax;
    frame_t e;
    prev = 1'b0; sh = 8'h0; run = 0; cnt = 0;
    hmin = 0; hmax = 0; lmin = 0; lmax = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0; run = 0; prev = spi_sclk;
      end else if (spi_sclk === prev) begin
        run++;
      end else begin
        if (!prev) begin
          if (cnt == 0) begin
            hmin = 1 << 30; hmax = 0; lmin = 1 << 30; lmax = 0;
          end else begin
            if (run < lmin) lmin = run;
            if (run > lmax) lmax = run;
          end
          sh = {sh[6:0], spi_mosi};
          cnt++;
        end else begin
          if (run < hmin) hmin = run;
          if (run > hmax) hmax = run;
          if (cnt == 8) begin
            if (exp_q.size() == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL unexpected_frame: got mosi 0x%02h, required no frame", sh);
            end else begin
              e = exp_q.pop_front();
              check("frame_mosi", {24'h0, sh}, {24'h0, e.mosi});
              check("frame_high_min", hmin, e.half);
              check("frame_high_max", hmax, e.half);
              check("frame_low_min", lmin, e.half);
              check("frame_low_max", lmax, e.half);
            end
            cnt = 0;
          end
        end
        run = 1;
        prev = spi_sclk;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    int n;
    frame_t f;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_cs_n", {31'h0, spi_cs_n}, 32'h1);
    check("reset_sclk", {31'h0, spi_sclk}, 32'h0);
    bus_read(4'h8, r); check("reset_ctrl", r, 32'h0000_0003);
    bus_read(4'h4, r); check("reset_status", r, 32'h0);
    bus_read(4'h0, r); check("reset_data", r, 32'h0);
    bus_read(4'hC, r); check("reg_c_reads_zero", r, 32'h0);

    // Loopback, DIV=0
    loop = 1'b1;
    bus_write(4'h8, 32'h000);
    f.mosi = 8'hA5; f.half = 1; exp_q.push_back(f);
    bus_write(4'h0, 32'hA5);
    wait_idle(n); check("div0_busy_cycles", n, 16);
    bus_read(4'h0, r); check("div0_rx", r, 32'hA5);
    bus_read(4'h4, r); check("div0_status", r, 32'h2);

    // DIV=3, MISO tied high; DATA read mid-transfer shows previous byte
    loop = 1'b0; miso_fix = 1'b1;
    bus_write(4'h8, 32'h003);
    f.mosi = 8'h3C; f.half = 4; exp_q.push_back(f);
    bus_write(4'h0, 32'h3C);
    bus_read(4'h0, r); check("rx_during_transfer", r, 32'hA5);
    bus_read(4'h4, r); check("busy_during_transfer", r, 32'h1);
    wait_idle(n); check("div3_busy_cycles", n, 64);
    bus_read(4'h0, r); check("div3_rx", r, 32'hFF);
    bus_read(4'h4, r); check("div3_status", r, 32'h2);

    // Overrun: second write two cycles later is dropped
    loop = 1'b1;
    bus_write(4'h8, 32'h000);
    f.mosi = 8'h11; f.half = 1; exp_q.push_back(f);
    bus_write(4'h0, 32'h11);
    bus_write(4'h0, 32'h22);
    wait_idle(n);
    bus_read(4'h0, r); check("overrun_rx", r, 32'h11);
    bus_read(4'h4, r); check("overrun_status", r, 32'h6);
    bus_write(4'h4, 32'h6);
    bus_read(4'h4, r); check("status_cleared", r, 32'h0);

    // CS control and mid-transfer DIV change
    bus_write(4'h8, 32'h100);
    check("cs_asserted", {31'h0, spi_cs_n}, 32'h0);
    bus_write(4'h8, 32'h101);
    f.mosi = 8'hC3; f.half = 2; exp_q.push_back(f);
    bus_write(4'h0, 32'hC3);
    bus_write(4'h8, 32'h107);
    wait_idle(n); check("div_latched_busy_cycles", n, 30);
    bus_read(4'h8, r); check("ctrl_readback", r, 32'h107);
    bus_read(4'h0, r); check("cs_rx", r, 32'hC3);
    check("cs_held", {31'h0, spi_cs_n}, 32'h0);

    // Reset mid-transfer at DIV=0
    bus_write(4'h8, 32'h100);
    bus_write(4'h0, 32'h5A);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_sclk", {31'h0, spi_sclk}, 32'h0);
    check("abort_cs_n", {31'h0, spi_cs_n}, 32'h1);
    bus_read(4'h4, r); check("abort_status", r, 32'h0);
    bus_read(4'h0, r); check("abort_rx", r, 32'h0);
    bus_read(4'h8, r); check("abort_ctrl", r, 32'h3);

    repeat (20) @(posedge clk);
    #1 check("frames_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
